// File: rtl/load_store_ramp.sv
// Ramp/oscillator: vol climbs to a latched limit, dwells, then falls (triangle) or snaps to 0 (sawtooth).
// Define LOAD_STORE_RAMP_IRQ_EN to add a sticky period-complete interrupt (irq / irq_clr).
module load_store_ramp #(
   parameter int CBITS = 12,
   parameter int SBITS = 4,
   parameter int DBITS = 8,
   parameter int PBITS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic [CBITS-1:0] limit,
   input  logic [SBITS-1:0] step,
   input  logic [DBITS-1:0] dwell,
   output logic [CBITS-1:0] vol,
   output logic             sig,
   output logic             at_low,
   output logic             rising,
   output logic             cfg_err,
   output logic [PBITS-1:0] period_cnt
`ifdef LOAD_STORE_RAMP_IRQ_EN
   ,
   input  logic             irq_clr,
   output logic             irq
`endif
);

   typedef enum logic [2:0] {IDLE, RISE, HOLD_HI, FALL, HOLD_LO} state_t;

   state_t           state, state_n;
   logic [CBITS-1:0] lim_q, lim_n, vol_n;
   logic [SBITS-1:0] step_q, step_n, step_in;
   logic [DBITS-1:0] dwell_q, dwell_n, dcnt, dcnt_n;
   logic             mode_q, mode_n, cfg_err_n;
   logic [PBITS-1:0] pcnt_n;
   logic [CBITS:0]   rise_sum;
   logic [CBITS-1:0] step_c, step_in_c;
   logic             fall_zero;

   assign step_in   = (step == '0) ? SBITS'(1) : step;
   assign step_c    = CBITS'(step_q);
   assign step_in_c = CBITS'(step_in);
   // One extra bit so a full-scale limit plus a step can never wrap.
   assign rise_sum  = {1'b0, vol} + {1'b0, step_c};
   assign fall_zero = (vol <= step_c);

   always_comb begin
      state_n   = state;
      vol_n     = vol;
      dcnt_n    = dcnt;
      lim_n     = lim_q;
      step_n    = step_q;
      dwell_n   = dwell_q;
      mode_n    = mode_q;
      pcnt_n    = period_cnt;
      cfg_err_n = cfg_err;
      if (en) begin
         case (state)
            IDLE: begin
               if (limit != '0) begin
                  lim_n     = limit;
                  step_n    = step_in;
                  dwell_n   = dwell;
                  mode_n    = mode;
                  cfg_err_n = 1'b0;
                  state_n   = RISE;
               end else begin
                  cfg_err_n = 1'b1;
               end
            end
            RISE: begin
               if (rise_sum >= {1'b0, lim_q}) begin
                  vol_n   = lim_q;
                  dcnt_n  = dwell_q;
                  state_n = HOLD_HI;
               end else begin
                  vol_n = rise_sum[CBITS-1:0];
               end
            end
            HOLD_HI: begin
               if (dcnt != '0) begin
                  dcnt_n = dcnt - DBITS'(1);
               end else if (mode_q || fall_zero) begin
                  // Sawtooth, or a triangle whose first fall step already reaches 0.
                  vol_n   = '0;
                  dcnt_n  = dwell_q;
                  state_n = HOLD_LO;
               end else begin
                  vol_n   = vol - step_c;
                  state_n = FALL;
               end
            end
            FALL: begin
               if (fall_zero) begin
                  vol_n   = '0;
                  dcnt_n  = dwell_q;
                  state_n = HOLD_LO;
               end else begin
                  vol_n = vol - step_c;
               end
            end
            HOLD_LO: begin
               if (dcnt != '0) begin
                  dcnt_n = dcnt - DBITS'(1);
               end else begin
                  pcnt_n  = period_cnt + PBITS'(1);
                  lim_n   = limit;
                  step_n  = step_in;
                  dwell_n = dwell;
                  mode_n  = mode;
                  if (limit == '0) begin
                     vol_n     = '0;
                     cfg_err_n = 1'b1;
                     state_n   = IDLE;
                  end else if (step_in_c >= limit) begin
                     vol_n   = limit;
                     dcnt_n  = dwell;
                     state_n = HOLD_HI;
                  end else begin
                     vol_n   = step_in_c;
                     state_n = RISE;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Flags are derived from the next state so they stay coherent with vol.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         vol        <= '0;
         dcnt       <= '0;
         lim_q      <= '0;
         step_q     <= '0;
         dwell_q    <= '0;
         mode_q     <= 1'b0;
         period_cnt <= '0;
         cfg_err    <= 1'b0;
         sig        <= 1'b0;
         at_low     <= 1'b0;
         rising     <= 1'b0;
      end else begin
         state      <= state_n;
         vol        <= vol_n;
         dcnt       <= dcnt_n;
         lim_q      <= lim_n;
         step_q     <= step_n;
         dwell_q    <= dwell_n;
         mode_q     <= mode_n;
         period_cnt <= pcnt_n;
         cfg_err    <= cfg_err_n;
         sig        <= (state_n == HOLD_HI);
         at_low     <= (state_n == HOLD_LO);
         rising     <= (state_n == RISE);
      end
   end

`ifdef LOAD_STORE_RAMP_IRQ_EN
   // A period completion in the same cycle as a clear keeps irq set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         irq <= 1'b0;
      else if (pcnt_n != period_cnt)
         irq <= 1'b1;
      else if (irq_clr)
         irq <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_load_store_ramp.sv
// Scoreboard bench for load_store_ramp: per-cycle stimulus and expected outputs queued, then replayed.
module tb_load_store_ramp;
   localparam int CBITS = 12;
   localparam int SBITS = 4;
   localparam int DBITS = 8;
   localparam int PBITS = 3;
`ifdef LOAD_STORE_RAMP_IRQ_EN
   localparam bit HAS_IRQ = 1'b1;
`else
   localparam bit HAS_IRQ = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic             mode = 1'b0;
   logic             irq_clr = 1'b0;
   logic [CBITS-1:0] limit = '0;
   logic [SBITS-1:0] step = '0;
   logic [DBITS-1:0] dwell = '0;
   logic [CBITS-1:0] vol;
   logic             sig, at_low, rising, cfg_err, irq;
   logic [PBITS-1:0] period_cnt;

   typedef struct packed {
      logic             en;
      logic             mode;
      logic [CBITS-1:0] limit;
      logic [SBITS-1:0] step;
      logic [DBITS-1:0] dwell;
      logic             clr;
   } stim_t;

   typedef struct packed {
      logic [CBITS-1:0] vol;
      logic             sig;
      logic             at_low;
      logic             rising;
      logic             cfg_err;
      logic [PBITS-1:0] pcnt;
      logic             irq;
   } obs_t;

   stim_t stim_q[$];
   obs_t  exp_q[$];
   stim_t cur;
   int    checks = 0;
   int    passed = 0;

   load_store_ramp #(.CBITS(CBITS), .SBITS(SBITS), .DBITS(DBITS), .PBITS(PBITS)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .limit(limit), .step(step),
      .dwell(dwell), .vol(vol), .sig(sig), .at_low(at_low), .rising(rising),
      .cfg_err(cfg_err), .period_cnt(period_cnt)
`ifdef LOAD_STORE_RAMP_IRQ_EN
      , .irq_clr(irq_clr), .irq(irq)
`endif
   );
`ifndef LOAD_STORE_RAMP_IRQ_EN
   assign irq = 1'b0;
`endif

   always #5 clk = ~clk;

   function automatic void set_cfg(input bit e, input bit m, input int lim, input int st, input int dw);
      cur.en    = e;
      cur.mode  = m;
      cur.limit = lim[CBITS-1:0];
      cur.step  = st[SBITS-1:0];
      cur.dwell = dw[DBITS-1:0];
      cur.clr   = 1'b0;
   endfunction

   // Queue one cycle: current stimulus plus the outputs expected after its clock edge.
   function automatic void add(input int v, input bit s, input bit lo, input bit r,
                               input bit err, input int p, input bit i);
      obs_t o;
      o.vol     = v[CBITS-1:0];
      o.sig     = s;
      o.at_low  = lo;
      o.rising  = r;
      o.cfg_err = err;
      o.pcnt    = p[PBITS-1:0];
      o.irq     = i & HAS_IRQ;
      stim_q.push_back(cur);
      exp_q.push_back(o);
   endfunction

   function automatic obs_t sample();
      return '{vol, sig, at_low, rising, cfg_err, period_cnt, irq};
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("vol=%0d sig=%b low=%b rise=%b err=%b pcnt=%0d irq=%b",
                       o.vol, o.sig, o.at_low, o.rising, o.cfg_err, o.pcnt, o.irq);
   endfunction

   task automatic apply(input stim_t s);
      en      = s.en;
      mode    = s.mode;
      limit   = s.limit;
      step    = s.step;
      dwell   = s.dwell;
      irq_clr = s.clr;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cur   = '0;
      apply(cur);
      #3;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      obs_t a, e;
      int   n = 0;
      do_reset();
      set_cfg(1, 0, 1, 15, 0);
      add(0, 0, 0, 1, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0);
      cur.limit = 20;
      cur.step  = 1;
      for (int v = 1; v <= 7; v++) add(v, 0, 0, 1, 0, 1, 1);
      while (exp_q.size() > 0) begin
         apply(stim_q.pop_front());
         e = exp_q.pop_front();
         @(posedge clk);
         #1;
         a = sample();
         n++;
         checks++;
         if (a !== e) $display("FAIL reset_pre[%0d] got %s want %s", n, fmt(a), fmt(e));
         else passed++;
      end
      #3;
      rst_n = 1'b0;
      #1;
      a = sample();
      checks++;
      if (a !== obs_t'(0)) $display("FAIL reset_async got %s want all zero", fmt(a));
      else passed++;
      #2;
      rst_n = 1'b1;
      set_cfg(1, 0, 3, 1, 0);
      add(0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 1, 0, 0, 0);
      add(2, 0, 0, 1, 0, 0, 0);
      add(3, 1, 0, 0, 0, 0, 0);
      n = 0;
      while (exp_q.size() > 0) begin
         apply(stim_q.pop_front());
         e = exp_q.pop_front();
         @(posedge clk);
         #1;
         a = sample();
         n++;
         checks++;
         if (a !== e) $display("FAIL reset_restart[%0d] got %s want %s", n, fmt(a), fmt(e));
         else passed++;
      end
   endtask

   task automatic test_triangle();
      obs_t a, e;
      int   n = 0;
      do_reset();
      set_cfg(1, 0, 5, 2, 0);
      add(0, 0, 0, 1, 0, 0, 0);
      add(2, 0, 0, 1, 0, 0, 0);
      add(4, 0, 0, 1, 0, 0, 0);
      add(5, 1, 0, 0, 0, 0, 0);
      add(3, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0);
      add(2, 0, 0, 1, 0, 1, 1);
      add(4, 0, 0, 1, 0, 1, 1);
      add(5, 1, 0, 0, 0, 1, 1);
      while (exp_q.size() > 0) begin
         apply(stim_q.pop_front());
         e = exp_q.pop_front();
         @(posedge clk);
         #1;
         a = sample();
         n++;
         checks++;
         if (a !== e) $display("FAIL triangle[%0d] got %s want %s", n, fmt(a), fmt(e));
         else passed++;
      end
   endtask

   task automatic test_sawtooth();
      obs_t a, e;
      int   n = 0;
      do_reset();
      set_cfg(1, 1, 3, 1, 2);
      for (int v = 0; v <= 2; v++) add(v, 0, 0, 1, 0, 0, 0);
      repeat (3) add(3, 1, 0, 0, 0, 0, 0);
      repeat (3) add(0, 0, 1, 0, 0, 0, 0);
      add(1, 0, 0, 1, 0, 1, 1);
      while (exp_q.size() > 0) begin
         apply(stim_q.pop_front());
         e = exp_q.pop_front();
         @(posedge clk);
         #1;
         a = sample();
         n++;
         checks++;
         if (a !== e) $display("FAIL sawtooth[%0d] got %s want %s", n, fmt(a), fmt(e));
         else passed++;
      end
   endtask

   task automatic test_zero_cfg();
      obs_t a, e;
      int   n = 0;
      do_reset();
      set_cfg(1, 0, 0, 0, 0);
      repeat (3) add(0, 0, 0, 0, 1, 0, 0);
      set_cfg(1, 0, 2, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 1, 0, 0, 0);
      add(2, 1, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0);
      cur.limit = 0;
      add(0, 0, 0, 0, 1, 1, 1);
      add(0, 0, 0, 0, 1, 1, 1);
      while (exp_q.size() > 0) begin
         apply(stim_q.pop_front());
         e = exp_q.pop_front();
         @(posedge clk);
         #1;
         a = sample();
         n++;
         checks++;
         if (a !== e) $display("FAIL zero_cfg[%0d] got %s want %s", n, fmt(a), fmt(e));
         else passed++;
      end
   endtask

   task automatic test_freeze();
      obs_t a, e;
      int   n = 0;
      do_reset();
      set_cfg(1, 0, 5, 1, 0);
      for (int v = 0; v <= 4; v++) add(v, 0, 0, 1, 0, 0, 0);
      cur.en    = 0;
      cur.limit = 9;
      repeat (4) add(4, 0, 0, 1, 0, 0, 0);
      cur.en = 1;
      add(5, 1, 0, 0, 0, 0, 0);
      for (int v = 4; v >= 1; v--) add(v, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0);
      for (int v = 1; v <= 8; v++) add(v, 0, 0, 1, 0, 1, 1);
      add(9, 1, 0, 0, 0, 1, 1);
      while (exp_q.size() > 0) begin
         apply(stim_q.pop_front());
         e = exp_q.pop_front();
         @(posedge clk);
         #1;
         a = sample();
         n++;
         checks++;
         if (a !== e) $display("FAIL freeze[%0d] got %s want %s", n, fmt(a), fmt(e));
         else passed++;
      end
   endtask

   task automatic test_max_limit();
      obs_t a, e;
      int   n = 0;
      do_reset();
      set_cfg(1, 0, 4095, 15, 0);
      add(0, 0, 0, 1, 0, 0, 0);
      for (int k = 1; k <= 272; k++) add(15 * k, 0, 0, 1, 0, 0, 0);
      add(4095, 1, 0, 0, 0, 0, 0);
      for (int j = 1; j <= 272; j++) add(4095 - 15 * j, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0);
      cur.clr = 1;
      add(15, 0, 0, 1, 0, 1, 1);
      add(30, 0, 0, 1, 0, 1, 0);
      while (exp_q.size() > 0) begin
         apply(stim_q.pop_front());
         e = exp_q.pop_front();
         @(posedge clk);
         #1;
         a = sample();
         n++;
         checks++;
         if (a !== e) $display("FAIL max_limit[%0d] got %s want %s", n, fmt(a), fmt(e));
         else passed++;
      end
   endtask

   task automatic test_period_wrap();
      obs_t a, e;
      int   n = 0;
      do_reset();
      set_cfg(1, 0, 1, 15, 0);
      add(0, 0, 0, 1, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0);
      for (int m = 1; m <= 9; m++) begin
         add(1, 1, 0, 0, 0, m % 8, 1);
         add(0, 0, 1, 0, 0, m % 8, 1);
      end
      while (exp_q.size() > 0) begin
         apply(stim_q.pop_front());
         e = exp_q.pop_front();
         @(posedge clk);
         #1;
         a = sample();
         n++;
         checks++;
         if (a !== e) $display("FAIL period_wrap[%0d] got %s want %s", n, fmt(a), fmt(e));
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_triangle();
      test_sawtooth();
      test_zero_cfg();
      test_freeze();
      test_max_limit();
      test_period_wrap();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
